// File: rtl/branch_resolve_table_if.sv
// branch_resolve_table_if: dispatch/resolve/commit bus of the branch resolve table.
// The master side (ROB, dispatch, branch RS) drives alloc/resolve/commit.
// The slave side (the table) returns commit_ready, the flush pulse and the redirect PC.
// It also returns debug views of the FSM state and of the per-entry valid/resolved bits.
interface branch_resolve_table_if #(
    parameter int ROB_DEPTH = 3
);
    localparam int ENTRIES = 1 << ROB_DEPTH;

    logic                 alloc_valid;
    logic [ROB_DEPTH-1:0] alloc_rob;
    logic [31:0]          alloc_pred_pc;

    logic                 resolve_valid;
    logic [ROB_DEPTH-1:0] resolve_rob;
    logic [31:0]          resolve_target_pc;

    logic                 commit_valid;
    logic [ROB_DEPTH-1:0] commit_rob;
    logic                 commit_ready;

    logic                 move_flush;
    logic [31:0]          redirect_pc;

    // Debug view: 1 while the FSM is in FLUSH, plus the entry flags.
    logic                 dbg_state;
    logic [ENTRIES-1:0]   dbg_valid;
    logic [ENTRIES-1:0]   dbg_resolved;

    modport master (
        output alloc_valid, alloc_rob, alloc_pred_pc,
        output resolve_valid, resolve_rob, resolve_target_pc,
        output commit_valid, commit_rob,
        input  commit_ready, move_flush, redirect_pc,
        input  dbg_state, dbg_valid, dbg_resolved
    );

    modport slave (
        input  alloc_valid, alloc_rob, alloc_pred_pc,
        input  resolve_valid, resolve_rob, resolve_target_pc,
        input  commit_valid, commit_rob,
        output commit_ready, move_flush, redirect_pc,
        output dbg_state, dbg_valid, dbg_resolved
    );
endinterface

// File: rtl/branch_resolve_table.sv
// branch_resolve_table: tracks in-flight control-flow instructions by ROB tag.
// It compares the predicted next PC with the resolved one at commit time.
// On a mispredict it raises a one-cycle move_flush together with redirect_pc.
//
// Optional feature: define BRT_STATS_EN to add the stat_branches and
// stat_mispredicts counters.
//
// Commit handshake: a commit is taken on a rising edge when commit_valid and
// commit_ready are both high. commit_ready drops only when the committing tag is
// tracked and still unresolved. While it is low, the ROB holds commit_valid and
// commit_rob stable.
// A resolve arriving in the same cycle as the commit is bypassed into the compare.
module branch_resolve_table #(
    parameter int ROB_DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    branch_resolve_table_if.slave         bus
`ifdef BRT_STATS_EN
    ,
    output logic [31:0]                   stat_branches,
    output logic [31:0]                   stat_mispredicts
`endif
);
    localparam int ENTRIES = 1 << ROB_DEPTH;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state;
    logic                flush_q;
    logic [31:0]         redirect_q;

    logic [ENTRIES-1:0]  valid;
    logic [ENTRIES-1:0]  resolved;
    logic [31:0]         pred_pc [ENTRIES];
    logic [31:0]         act_pc  [ENTRIES];

    logic                resolve_hit;
    logic                commit_ready;
    logic [31:0]         act_eff;
    logic                mispredict;
    logic                commit_fire;
    logic                resolve_fire;
    logic                alloc_fire;

    // Decode this cycle's events; everything is gated off while flushing.
    always_comb begin
        resolve_hit  = bus.resolve_valid && (bus.resolve_rob == bus.commit_rob);
        commit_ready = !bus.commit_valid
                    || !valid[bus.commit_rob]
                    || resolved[bus.commit_rob]
                    || resolve_hit;
        act_eff      = resolve_hit ? bus.resolve_target_pc : act_pc[bus.commit_rob];
        mispredict   = (act_eff != pred_pc[bus.commit_rob]);
        commit_fire  = (state == IDLE) && bus.commit_valid
                    && valid[bus.commit_rob] && commit_ready;
        resolve_fire = (state == IDLE) && bus.resolve_valid && valid[bus.resolve_rob];
        alloc_fire   = (state == IDLE) && bus.alloc_valid;
    end

    // Entry storage.
    // The writes are ordered resolve, then commit-clear, then alloc.
    // Because the later non-blocking write wins, alloc beats commit on the same tag.
    // Resolve against a not-yet-valid tag was already rejected by resolve_fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= '0;
            resolved <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                pred_pc[i] <= 32'h0;
                act_pc[i]  <= 32'h0;
            end
        end else if (state == FLUSH) begin
            valid    <= '0;
            resolved <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                pred_pc[i] <= 32'h0;
                act_pc[i]  <= 32'h0;
            end
        end else begin
            if (resolve_fire) begin
                resolved[bus.resolve_rob] <= 1'b1;
                act_pc[bus.resolve_rob]   <= bus.resolve_target_pc;
            end
            if (commit_fire) begin
                valid[bus.commit_rob]    <= 1'b0;
                resolved[bus.commit_rob] <= 1'b0;
                pred_pc[bus.commit_rob]  <= 32'h0;
                act_pc[bus.commit_rob]   <= 32'h0;
            end
            if (alloc_fire) begin
                valid[bus.alloc_rob]    <= 1'b1;
                resolved[bus.alloc_rob] <= 1'b0;
                pred_pc[bus.alloc_rob]  <= bus.alloc_pred_pc;
                act_pc[bus.alloc_rob]   <= 32'h0;
            end
        end
    end

    // Flush FSM: a committed mispredict enters FLUSH for exactly one cycle.
    // move_flush and redirect_pc come straight from registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            flush_q    <= 1'b0;
            redirect_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit_fire && mispredict) begin
                        state      <= FLUSH;
                        flush_q    <= 1'b1;
                        redirect_q <= act_eff;
                    end else begin
                        flush_q    <= 1'b0;
                    end
                end
                FLUSH: begin
                    state   <= IDLE;
                    flush_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRT_STATS_EN
    // Statistics: commits of tracked entries, and entries into FLUSH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= 32'h0;
            stat_mispredicts <= 32'h0;
        end else begin
            if (commit_fire) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (commit_fire && mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

    assign bus.commit_ready = commit_ready;
    assign bus.move_flush   = flush_q;
    assign bus.redirect_pc  = redirect_q;
    assign bus.dbg_state    = (state == FLUSH);
    assign bus.dbg_valid    = valid;
    assign bus.dbg_resolved = resolved;

endmodule
